// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity-type constants and
// frame-length helper used to size the receiver's bit-position counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int unsigned EVEN = 0;
    localparam int unsigned ODD  = 1;

    // Bits on the line for one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input int unsigned par_en);
        return 2 + data_width + par_en;
    endfunction

endpackage

// File: rtl/uart_rx_mv_if.sv
// Received-word handshake bundle between uart_rx_mv and its consumer.
//   DATA_VALID   : a received word is held on P_DATA_OUT
//   DATA_READY   : consumer accepts the held word
//   P_DATA_OUT   : received word
//   parity_error / stop_error / break_det : status held with the word
//   overrun      : one-cycle pulse when a completed frame is dropped
interface uart_rx_mv_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  DATA_VALID;
    logic                  DATA_READY;
    logic [DATA_WIDTH-1:0] P_DATA_OUT;
    logic                  parity_error;
    logic                  stop_error;
    logic                  break_det;
    logic                  overrun;

    modport master (
        output DATA_VALID,
        output P_DATA_OUT,
        output parity_error,
        output stop_error,
        output break_det,
        output overrun,
        input  DATA_READY
    );

    modport slave (
        input  DATA_VALID,
        input  P_DATA_OUT,
        input  parity_error,
        input  stop_error,
        input  break_det,
        input  overrun,
        output DATA_READY
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk : destination clock
//   rst : synchronous, active-high reset; both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_mv.sv
// Oversampling UART receiver with 3-sample majority vote per bit,
// false-start rejection, break detection and a held-valid output register
// with overrun reporting.
//   clk   : receiver clock, N x bit rate
//   rst   : synchronous, active-high reset
//   RX_IN : asynchronous serial line, idles high
//   rx_if : received-word handshake (master side)
module uart_rx_mv
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PAR_EN     = 1,
    parameter int unsigned PAR_TYPE   = EVEN,
    parameter int unsigned N          = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RX_IN,
    uart_rx_mv_if.master rx_if
);

    localparam int unsigned CW         = $clog2(N);
    localparam int unsigned FRAME_BITS = frame_len(DATA_WIDTH, PAR_EN);
    localparam int unsigned BW         = $clog2(FRAME_BITS);

    localparam logic [CW-1:0] CNT_S0   = CW'(N / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(N / 2);
    localparam logic [CW-1:0] CNT_VOTE = CW'(N / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // Three distinct sample points must fit inside one bit.
    if (N < 4) begin : g_n_check
        $error("uart_rx_mv: N must be at least 4");
    end

    logic                  rxs;
    rx_state_e             state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic                  s0;
    logic                  s1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;

    logic          vote_c;
    logic          at_vote_c;
    logic          at_wrap_c;
    logic          complete_c;
    logic          par_err_c;
    logic          brk_c;
    logic [CW-1:0] cnt_next_c;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (RX_IN),
        .q   (rxs)
    );

    // Two-of-three majority; the third sample is the live line at CNT_VOTE.
    assign vote_c     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign at_vote_c  = (cnt == CNT_VOTE);
    assign at_wrap_c  = (cnt == CNT_LAST);
    assign cnt_next_c = at_wrap_c ? '0 : cnt + CW'(1);
    assign complete_c = (state == STOP) && at_vote_c;

    // Parity over data plus received parity bit must match the selected sense.
    assign par_err_c = (PAR_EN != 0) &&
                       ((^shreg ^ par_bit) != (PAR_TYPE == ODD));

    // par_bit stays 0 when parity is disabled, so it never masks a break.
    assign brk_c = (shreg == '0) && !par_bit && !vote_c;

    // Frame FSM, bit timing and sample capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (cnt == CNT_S0) s0 <= rxs;
            if (cnt == CNT_S1) s1 <= rxs;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    // The detecting cycle is cnt=0 of the start bit.
                    if (!rxs) begin
                        state <= START;
                        cnt   <= CW'(1);
                    end
                end

                START: begin
                    cnt <= cnt_next_c;
                    if (at_vote_c && vote_c) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (at_wrap_c) begin
                        state   <= DATA;
                        bit_idx <= BW'(1);
                    end
                end

                DATA: begin
                    cnt <= cnt_next_c;
                    if (at_vote_c) shreg <= DATA_WIDTH'({vote_c, shreg} >> 1);
                    if (at_wrap_c) begin
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == BW'(DATA_WIDTH))
                            state <= (PAR_EN != 0) ? PARITY : STOP;
                    end
                end

                PARITY: begin
                    cnt <= cnt_next_c;
                    if (at_vote_c) par_bit <= vote_c;
                    if (at_wrap_c) begin
                        state   <= STOP;
                        bit_idx <= bit_idx + BW'(1);
                    end
                end

                STOP: begin
                    cnt <= cnt_next_c;
                    // Leave at the vote so a following start edge is not missed.
                    if (at_vote_c) begin
                        state <= vote_c ? IDLE : WAIT_IDLE;
                        cnt   <= '0;
                    end
                end

                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rxs) state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output word register: load on completion unless a word is held and not
    // being taken this cycle, in which case the new frame is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_if.DATA_VALID   <= 1'b0;
            rx_if.P_DATA_OUT   <= '0;
            rx_if.parity_error <= 1'b0;
            rx_if.stop_error   <= 1'b0;
            rx_if.break_det    <= 1'b0;
            rx_if.overrun      <= 1'b0;
        end else begin
            rx_if.overrun <= 1'b0;
            if (complete_c && (!rx_if.DATA_VALID || rx_if.DATA_READY)) begin
                rx_if.DATA_VALID   <= 1'b1;
                rx_if.P_DATA_OUT   <= shreg;
                rx_if.parity_error <= par_err_c;
                rx_if.stop_error   <= !vote_c;
                rx_if.break_det    <= brk_c;
            end else if (complete_c) begin
                rx_if.overrun <= 1'b1;
            end else if (rx_if.DATA_READY) begin
                rx_if.DATA_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_mv.sv
// Directed scoreboard bench for uart_rx_mv: stimulus pushes expected words,
// per-DUT monitors pop and compare whenever a new word is presented.
module tb_uart_rx_mv;
    import uart_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned F = frame_len(8, 1);

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       serr;
        logic       brk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx0;
    logic rx1;
    int   cyc = 0;

    int checks = 0;
    int fails  = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   expw0 = 0;
    int   words0 = 0;
    int   words1 = 0;
    int   ovr0 = 0;
    int   rise0 = -1;
    logic v0_prev = 1'b0;
    logic v1_prev = 1'b0;

    uart_rx_mv_if #(.DATA_WIDTH(8)) if0 ();
    uart_rx_mv_if #(.DATA_WIDTH(8)) if1 ();

    uart_rx_mv #(
        .DATA_WIDTH (8),
        .PAR_EN     (1),
        .PAR_TYPE   (EVEN),
        .N          (N)
    ) dut0 (
        .clk   (clk),
        .rst   (rst),
        .RX_IN (rx0),
        .rx_if (if0)
    );

    uart_rx_mv #(
        .DATA_WIDTH (8),
        .PAR_EN     (1),
        .PAR_TYPE   (ODD),
        .N          (N)
    ) dut1 (
        .clk   (clk),
        .rst   (rst),
        .RX_IN (rx1),
        .rx_if (if1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d, input logic p, input logic s, input logic b);
        exp_t e;
        e = '{data: d, perr: p, serr: s, brk: b};
        q0.push_back(e);
        expw0++;
    endtask

    // Frame bits LSB first: start, data, parity, stop; N clocks each.
    task automatic send_frame(input int sel, input logic [7:0] d, input logic p, input logic s);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < int'(F); i++) begin
            if (sel == 0) rx0 = bits[i];
            else          rx1 = bits[i];
            repeat (N) @(negedge clk);
        end
    endtask

    // Monitor dut0: a new word is presented when valid rises or is refilled
    // on the same edge it was accepted.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (if0.overrun === 1'b1) ovr0++;
        if (if0.DATA_VALID === 1'b1 && (!v0_prev || if0.DATA_READY === 1'b1)) begin
            words0++;
            if (!v0_prev) rise0 = cyc;
            if (q0.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL dut0 unexpected word: got 0x%0h expected none", if0.P_DATA_OUT);
            end else begin
                e = q0.pop_front();
                check("dut0 data", 32'(if0.P_DATA_OUT), 32'(e.data));
                check("dut0 parity_error", 32'(if0.parity_error), 32'(e.perr));
                check("dut0 stop_error", 32'(if0.stop_error), 32'(e.serr));
                check("dut0 break_det", 32'(if0.break_det), 32'(e.brk));
            end
        end
        v0_prev = (if0.DATA_VALID === 1'b1);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (if1.DATA_VALID === 1'b1 && (!v1_prev || if1.DATA_READY === 1'b1)) begin
            words1++;
            if (q1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL dut1 unexpected word: got 0x%0h expected none", if1.P_DATA_OUT);
            end else begin
                e = q1.pop_front();
                check("dut1 data", 32'(if1.P_DATA_OUT), 32'(e.data));
                check("dut1 parity_error", 32'(if1.parity_error), 32'(e.perr));
                check("dut1 stop_error", 32'(if1.stop_error), 32'(e.serr));
                check("dut1 break_det", 32'(if1.break_det), 32'(e.brk));
            end
        end
        v1_prev = (if1.DATA_VALID === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int ovr_base;
        exp_t e1;

        rst = 1'b1;
        rx0 = 1'b1;
        rx1 = 1'b1;
        if0.DATA_READY = 1'b0;
        if1.DATA_READY = 1'b1;
        repeat (3) @(negedge clk);

        check("reset valid", 32'(if0.DATA_VALID), 0);
        check("reset data", 32'(if0.P_DATA_OUT), 0);
        check("reset parity_error", 32'(if0.parity_error), 0);
        check("reset stop_error", 32'(if0.stop_error), 0);
        check("reset break_det", 32'(if0.break_det), 0);
        check("reset overrun", 32'(if0.overrun), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5, even parity bit 0, good stop; valid 46 clocks after the line falls.
        push0(8'hA5, 1'b0, 1'b0, 1'b0);
        c = cyc;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("A5 valid rise cycle", 32'(rise0), 32'(c + 46));
        check("A5 valid held", 32'(if0.DATA_VALID), 1);
        if0.DATA_READY = 1'b1;
        @(negedge clk);
        check("A5 valid cleared after ready", 32'(if0.DATA_VALID), 0);
        if0.DATA_READY = 1'b0;

        // Odd-parity receiver given an even-parity frame flags parity_error.
        e1 = '{data: 8'h3C, perr: 1'b1, serr: 1'b0, brk: 1'b0};
        q1.push_back(e1);
        send_frame(1, 8'h3C, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("dut1 word count", 32'(words1), 1);

        // Bad stop then recovery with a clean 0x55.
        if0.DATA_READY = 1'b1;
        push0(8'h5A, 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b0);
        rx0 = 1'b1;
        repeat (8) @(negedge clk);
        push0(8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h55, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("stop error words", 32'(words0), 32'(expw0));

        // Break: line low for a full frame and beyond; one word only.
        push0(8'h00, 1'b0, 1'b1, 1'b1);
        rx0 = 1'b0;
        repeat (F * N + 40) @(negedge clk);
        check("break single word", 32'(words0), 32'(expw0));
        rx0 = 1'b1;
        repeat (8) @(negedge clk);

        // 1-clock glitch, then a frame exactly when the FSM is back in IDLE.
        rx0 = 1'b0;
        @(negedge clk);
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        push0(8'h96, 1'b0, 1'b0, 1'b0);
        c = cyc;
        send_frame(0, 8'h96, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("post-glitch valid rise cycle", 32'(rise0), 32'(c + 46));
        // 2-clock glitch is also rejected.
        rx0 = 1'b0;
        repeat (2) @(negedge clk);
        rx0 = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch no word", 32'(words0), 32'(expw0));

        // Back-to-back 0x11, 0x22 with no consumer: 0x22 dropped.
        if0.DATA_READY = 1'b0;
        ovr_base = ovr0;
        push0(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("overrun pulses", 32'(ovr0 - ovr_base), 1);
        check("overrun valid held", 32'(if0.DATA_VALID), 1);
        check("overrun data kept", 32'(if0.P_DATA_OUT), 32'h11);
        if0.DATA_READY = 1'b1;
        @(negedge clk);
        if0.DATA_READY = 1'b0;

        // Same pair with ready asserted in the second vote cycle: 0x22 refills.
        ovr_base = ovr0;
        push0(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h11, 1'b0, 1'b1);
        push0(8'h22, 1'b0, 1'b0, 1'b0);
        c = cyc;
        fork
            send_frame(0, 8'h22, 1'b0, 1'b1);
            begin
                repeat (45) @(negedge clk);
                if0.DATA_READY = 1'b1;
                @(negedge clk);
                if0.DATA_READY = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check("refill no overrun", 32'(ovr0 - ovr_base), 0);
        check("refill valid", 32'(if0.DATA_VALID), 1);
        check("refill data", 32'(if0.P_DATA_OUT), 32'h22);

        // Reset in the middle of a frame while a word is held.
        ovr_base = ovr0;
        fork
            send_frame(0, 8'hF8, 1'b1, 1'b1);
            begin
                repeat (12) @(negedge clk);
                rst = 1'b1;
                repeat (8) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("midreset valid", 32'(if0.DATA_VALID), 0);
        check("midreset data", 32'(if0.P_DATA_OUT), 0);
        check("midreset flags", 32'({if0.parity_error, if0.stop_error, if0.break_det}), 0);
        check("midreset overrun", 32'(ovr0 - ovr_base), 0);
        check("midreset no word", 32'(words0), 32'(expw0));

        check("dut0 queue drained", 32'(q0.size()), 0);
        check("dut1 queue drained", 32'(q1.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
